hex_word_tx_sequencer: RTL

Sequences the conversion of a multi-nibble binary word into a stream of lowercase ASCII hex characters, one byte per handshake, for transmission over the byte-oriented serial/display path. It accepts a word through a valid/ready handshake and walks the nibbles MSB-first through a lowercase hex-to-ASCII mapping. It can prefix "0x" and terminate with CR LF. It sits between the word producers (debug/status registers, calculator results) and the UART transmit byte interface.

---
 rtl/hex_word_tx_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/hex_word_tx_sequencer.sv
// Converts a NIBBLES-digit binary word into a lowercase ASCII hex byte stream,
// with optional "0x" prefix and CR LF trailer, one byte per valid/ready handshake.
module hex_word_tx_sequencer #(
  parameter int NIBBLES = 8,
  parameter int PREFIX  = 0,
  parameter int CRLF    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NIBBLES-1:0]   word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT, CR, LF} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  shreg;
  logic [CW-1:0] digit_cnt;
  logic [3:0]    nib;
  logic          accept, hs;

  // Handshake terms feed only next-state/datapath logic; every output is
  // decoded from registered state, so no input reaches an output combinationally.
  assign accept = word_valid & word_ready;
  assign hs     = byte_valid & byte_ready;
  assign nib    = shreg[W-1 -: 4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      digit_cnt <= '0;
    end else if (accept) begin
      shreg     <= word_in;
      digit_cnt <= CW'(NIBBLES - 1);
    end else if (hs && state == DIGIT && digit_cnt != '0) begin
      shreg     <= shreg << 4;
      digit_cnt <= digit_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (PREFIX != 0) ? PFX0 : DIGIT;
      PFX0:    if (hs) state_nxt = PFX1;
      PFX1:    if (hs) state_nxt = DIGIT;
      DIGIT:   if (hs && digit_cnt == '0) state_nxt = (CRLF != 0) ? CR : IDLE;
      CR:      if (hs) state_nxt = LF;
      LF:      if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    word_ready = 1'b0;
    byte_valid = 1'b1;
    busy       = 1'b1;
    byte_out   = 8'h20;
    case (state)
      IDLE: begin
        word_ready = 1'b1;
        byte_valid = 1'b0;
        busy       = 1'b0;
      end
      PFX0:  byte_out = 8'h30;
      PFX1:  byte_out = 8'h78;
      DIGIT: byte_out = (nib < 4'd10) ? {4'h3, nib} : 8'h57 + {4'h0, nib};
      CR:    byte_out = 8'h0D;
      LF:    byte_out = 8'h0A;
      default: begin
        byte_valid = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end
endmodule
